scan_display_mux: RTL
=====================

Name: scan_display_mux

Overview:
- Parametrised time-multiplexed scan driver for common-anode/cathode multi-digit 7-segment displays.
- Successor to the fixed 3-digit, free-running 2-bit-counter display mux. Adds:
  - digit count, code width and scan rate set by parameters;
  - a per-digit enable mask with slot skipping;
  - leading-zero suppression;
  - anti-ghosting blank interval between digits;
  - a per-frame snapshot of the inputs, so the display never tears.
- Sits between the counter/timer BCD sources and the external BCD-to-7-segment decoder and digit transistors.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); index 0 is the least significant digit.
- DIG_W, 4, code width per digit (BCD = 4).
- SCAN_DIV, 1000, clk cycles per digit slot, blank interval included; must be greater than BLANK_CYC.
- BLANK_CYC, 16, cycles at the start of each slot with all digits off; 0 disables blanking.
- SEL_ACTIVE_LOW, 1, when 1 an active digit_sel bit is driven 0; when 0 it is driven 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- digits_in, input, NUM_DIGITS*DIG_W, packed digit codes; digit i is bits [i*DIG_W +: DIG_W].
- digit_en, input, NUM_DIGITS, per-digit enable mask; a disabled digit gets no slot.
- lz_blank, input, 1, leading-zero suppression enable.
- code_out, output, DIG_W, code of the digit currently shown (goes to the decoder).
- digit_sel, output, NUM_DIGITS, one-hot digit drive, polarity set by SEL_ACTIVE_LOW.
- digit_idx, output, clog2(NUM_DIGITS), index of the current slot.
- frame_start, output, 1, one-cycle pulse on the first cycle of every frame.

Behaviour:
- Reset (asynchronous, dominates everything), state IDLE:
  - prescaler = 0, digit_idx = 0;
  - all shadow registers = 0;
  - code_out = 0;
  - digit_sel = all inactive;
  - frame_start = 0.
- All outputs are registered.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - On the first rising edge with reset low, capture the shadow registers (sh_digits <= digits_in, sh_en <= digit_en, sh_lz <= lz_blank).
  - digit_idx <= lowest set bit of digit_en, or 0 if none is set; prescaler <= 0.
  - frame_start <= 1.
  - Next state is BLANK if BLANK_CYC > 0, otherwise SHOW.
- Prescaler: counts 0..SCAN_DIV-1 in BLANK and SHOW, and wraps to 0.
  - BLANK holds while prescaler < BLANK_CYC.
  - On the edge where the prescaler reaches BLANK_CYC, state <= SHOW.
- During BLANK: digit_sel is all inactive and code_out = 0.
- During SHOW: code_out = sh_digits[digit_idx]; only digit_sel[digit_idx] is active, unless that digit is suppressed.
- Leading-zero suppression:
  - A digit k is suppressed when sh_lz = 1, k != 0, and every sh_digits[j] == 0 for j = k..NUM_DIGITS-1.
  - A suppressed digit keeps its slot (constant duty cycle); only digit_sel is inactive, and code_out still carries the code.
- Slot end (edge where prescaler == SCAN_DIV-1):
  - digit_idx <= next index above the current one with sh_en set, searching upward.
  - If the search passes NUM_DIGITS-1 this is a frame boundary: recapture the shadow registers from the inputs, then idx <= lowest set bit of the newly captured enable mask, and pulse frame_start for one cycle.
  - State <= BLANK, or SHOW when BLANK_CYC == 0.
- Empty enable mask (sh_en == 0):
  - Slots keep running with digit_idx = 0 and digit_sel all inactive.
  - Every slot is a frame boundary, so a newly enabled digit appears within one slot.
- Inputs that change mid-frame have no effect until the next frame boundary.
- Reset asserted mid-slot: outputs go to their reset values immediately, with no clk edge needed.
- Frame period = SCAN_DIV × popcount(sh_en) cycles, or SCAN_DIV cycles when the mask is empty.

Test Plan (NUM_DIGITS=4, DIG_W=4, SCAN_DIV=8, BLANK_CYC=2, SEL_ACTIVE_LOW=1):
- Reset, then release with digits_in=0x4321, digit_en=0xF, lz_blank=0 → frame_start pulses; per slot: 2 cycles with digit_sel=1111 and code_out=0, then 6 cycles with digit_sel=1110/1101/1011/0111 and code_out=1/2/3/4; frame_start repeats every 32 cycles.
- digit_en=0b0101 → only idx 0 and 2 are scanned; frame period is 16 cycles; idx 1 and 3 are never selected.
- digits_in=0x0070, lz_blank=1 → digits 3 and 2 are suppressed (digit_sel stays 1111 in their SHOW cycles), digits 1 and 0 are shown (7, 0); with digits_in=0x0000, only digit 0 is shown.
- Change digits_in from 0x1111 to 0x9999 in the middle of slot 1 → slots 1–3 still show 1; the new frame shows 9 from slot 0.
- Assert reset in the middle of a SHOW cycle → digit_sel=1111, code_out=0 and frame_start=0 in the same cycle; after release a new frame starts at idx 0.
- digit_en=0 → digit_sel stays 1111; set digit_en=0b1000 → digit 3 is shown within at most 8+2 cycles.

Source files
------------

// File: rtl/scan_display_mux_if.sv
// Bus between the BCD sources / display hardware and the scan driver.
//   master : drives digits_in, digit_en, lz_blank; observes the display outputs
//   slave  : the scan driver itself
interface scan_display_mux_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIG_W      = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS*DIG_W-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic                        lz_blank;
    logic [DIG_W-1:0]            code_out;
    logic [NUM_DIGITS-1:0]       digit_sel;
    logic [IDX_W-1:0]            digit_idx;
    logic                        frame_start;

    modport master (
        output digits_in, digit_en, lz_blank,
        input  code_out, digit_sel, digit_idx, frame_start
    );

    modport slave (
        input  digits_in, digit_en, lz_blank,
        output code_out, digit_sel, digit_idx, frame_start
    );
endinterface

// File: rtl/scan_display_mux.sv
// Time-multiplexed multi-digit 7-segment scan driver.
// Each enabled digit gets a slot of SCAN_DIV cycles: BLANK_CYC cycles with all
// digits off (anti-ghosting), then the digit is driven. Inputs are snapshotted
// once per frame so a frame never mixes old and new values.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave modport: digits_in/digit_en/lz_blank in,
//           code_out/digit_sel/digit_idx/frame_start out (all registered)
module scan_display_mux #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIG_W          = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    scan_display_mux_if.slave     bus
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW    = NUM_DIGITS * DIG_W;
    // Value of digit_sel with every digit off
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state;
    logic [PS_W-1:0]       prescaler;
    logic [DW-1:0]         sh_digits;
    logic [NUM_DIGITS-1:0] sh_en;
    logic                  sh_lz;

    logic                  next_found;
    logic [IDX_W-1:0]      next_up;
    logic [IDX_W-1:0]      cap_idx;
    logic                  frame_wrap;
    logic [IDX_W-1:0]      end_idx;
    logic [DW-1:0]         end_digits;
    logic [NUM_DIGITS-1:0] end_en;
    logic                  end_lz;
    logic                  slot_end;
    logic                  blank_done;

    // Lowest set bit of an enable mask, 0 when empty
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_DIGITS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int j = int'(NUM_DIGITS) - 1; j >= 0; j--) begin
            if (m[j]) r = IDX_W'(j);
        end
        return r;
    endfunction

    function automatic logic [DIG_W-1:0] code_of(input logic [DW-1:0] d,
                                                 input logic [IDX_W-1:0] i);
        return d[32'(i)*DIG_W +: DIG_W];
    endfunction

    // Drive pattern for slot i: off when the digit is disabled or is a
    // suppressed leading zero (all digits from i upward are zero)
    function automatic logic [NUM_DIGITS-1:0] sel_of(input logic [DW-1:0]         d,
                                                     input logic [NUM_DIGITS-1:0] en,
                                                     input logic                  lz,
                                                     input logic [IDX_W-1:0]      i);
        logic [NUM_DIGITS-1:0] raw;
        logic                  upper_zero;
        raw        = '0;
        upper_zero = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (j >= 32'(i) && d[j*DIG_W +: DIG_W] != '0) upper_zero = 1'b0;
        end
        if (en[i] && !(lz && i != '0 && upper_zero)) raw[i] = 1'b1;
        return raw ^ SEL_OFF;
    endfunction

    // Next enabled slot above the current one; none found means frame boundary
    always_comb begin
        next_found = 1'b0;
        next_up    = '0;
        for (int j = int'(NUM_DIGITS) - 1; j >= 0; j--) begin
            if (j > int'(bus.digit_idx) && sh_en[j]) begin
                next_found = 1'b1;
                next_up    = IDX_W'(j);
            end
        end
    end

    // Slot-end values, taking a fresh snapshot at a frame boundary
    always_comb begin
        cap_idx    = lowest(bus.digit_en);
        frame_wrap = !next_found;
        end_idx    = frame_wrap ? cap_idx       : next_up;
        end_digits = frame_wrap ? bus.digits_in : sh_digits;
        end_en     = frame_wrap ? bus.digit_en  : sh_en;
        end_lz     = frame_wrap ? bus.lz_blank  : sh_lz;
        slot_end   = (prescaler == PS_W'(SCAN_DIV - 1));
        blank_done = (BLANK_CYC != 0) && (prescaler == PS_W'(BLANK_CYC - 1));
    end

    // Scan FSM, prescaler, snapshot and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            prescaler       <= '0;
            sh_digits       <= '0;
            sh_en           <= '0;
            sh_lz           <= 1'b0;
            bus.digit_idx   <= '0;
            bus.code_out    <= '0;
            bus.digit_sel   <= SEL_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    sh_digits       <= bus.digits_in;
                    sh_en           <= bus.digit_en;
                    sh_lz           <= bus.lz_blank;
                    bus.digit_idx   <= cap_idx;
                    prescaler       <= '0;
                    bus.frame_start <= 1'b1;
                    if (BLANK_CYC == 0) begin
                        state         <= SHOW;
                        bus.code_out  <= code_of(bus.digits_in, cap_idx);
                        bus.digit_sel <= sel_of(bus.digits_in, bus.digit_en,
                                                bus.lz_blank, cap_idx);
                    end else begin
                        state         <= BLANK;
                        bus.code_out  <= '0;
                        bus.digit_sel <= SEL_OFF;
                    end
                end
                BLANK, SHOW: begin
                    if (slot_end) begin
                        prescaler     <= '0;
                        bus.digit_idx <= end_idx;
                        if (frame_wrap) begin
                            sh_digits       <= bus.digits_in;
                            sh_en           <= bus.digit_en;
                            sh_lz           <= bus.lz_blank;
                            bus.frame_start <= 1'b1;
                        end
                        if (BLANK_CYC == 0) begin
                            state         <= SHOW;
                            bus.code_out  <= code_of(end_digits, end_idx);
                            bus.digit_sel <= sel_of(end_digits, end_en, end_lz, end_idx);
                        end else begin
                            state         <= BLANK;
                            bus.code_out  <= '0;
                            bus.digit_sel <= SEL_OFF;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                        if (state == BLANK && blank_done) begin
                            state         <= SHOW;
                            bus.code_out  <= code_of(sh_digits, bus.digit_idx);
                            bus.digit_sel <= sel_of(sh_digits, sh_en, sh_lz, bus.digit_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
